ifetch_unit: RTL and testbench

// - Instruction-fetch stage directly upstream of the decoder. Owns the PC, issues word fetches to instruction memory and presents inst/pc to decode.
// - Handles variable-latency memory (one outstanding request), downstream stall (one-entry skid) and branch/jump redirect with stale-response squash.

---
 rtl/ifetch_unit.sv | 178 +++++++++++++++++
 tb/tb_ifetch_unit.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// ifetch_unit: owns the PC, fetches one word at a time, skids one word on stall.
// Define IFETCH_MISALIGN_CHECK_EN to trap misaligned redirect targets on misalign_o.
module ifetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_rvalid,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] inst_o,
   output logic [31:0] pc_o,
   output logic [31:0] pc4_o,
   output logic        inst_valid
`ifdef IFETCH_MISALIGN_CHECK_EN
   ,
   output logic        misalign_o
`endif
);

`ifdef IFETCH_MISALIGN_CHECK_EN
   typedef enum logic [2:0] {
      S_BOOT, S_FETCH, S_HOLD, S_FLUSH, S_TRAP
   } state_t;
   logic mis_q, mis_d;
   logic owe_q, owe_d;
`else
   typedef enum logic [2:0] {
      S_BOOT, S_FETCH, S_HOLD, S_FLUSH
   } state_t;
`endif

   state_t      state_q, state_d;
   logic [31:0] fpc_q, fpc_d;
   logic        req_q, req_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pc4_q, pc4_d;
   logic        vld_q, vld_d;
   logic [31:0] skid_inst_q, skid_inst_d;
   logic [31:0] skid_pc_q, skid_pc_d;
   logic [31:0] tgt;
   logic        pend;

   always_comb begin
      state_d     = state_q;
      fpc_d       = fpc_q;
      inst_d      = inst_q;
      pc_d        = pc_q;
      pc4_d       = pc4_q;
      vld_d       = vld_q;
      skid_inst_d = skid_inst_q;
      skid_pc_d   = skid_pc_q;
      tgt         = redirect_pc & 32'hFFFF_FFFC;
      pend        = (state_q == S_FETCH) || (state_q == S_FLUSH);
`ifdef IFETCH_MISALIGN_CHECK_EN
      mis_d = mis_q;
      owe_d = owe_q;
      pend  = pend || ((state_q == S_TRAP) && owe_q);
`endif

      unique case (state_q)
         S_BOOT: state_d = S_FETCH;
         S_FETCH: begin
            if (imem_rvalid) begin
               fpc_d = fpc_q + 32'd4;
               if (!vld_q || !stall) begin
                  inst_d = imem_rdata;
                  pc_d   = fpc_q;
                  pc4_d  = fpc_q + 32'd4;
                  vld_d  = 1'b1;
               end else begin
                  skid_inst_d = imem_rdata;
                  skid_pc_d   = fpc_q;
                  state_d     = S_HOLD;
               end
            end else if (vld_q && !stall) begin
               vld_d  = 1'b0;
               inst_d = NOP_INST;
            end
         end
         S_HOLD: begin
            if (!stall) begin
               inst_d      = skid_inst_q;
               pc_d        = skid_pc_q;
               pc4_d       = skid_pc_q + 32'd4;
               skid_inst_d = 32'h0;
               skid_pc_d   = 32'h0;
               state_d     = S_FETCH;
            end
         end
         S_FLUSH: begin
            if (imem_rvalid) state_d = S_FETCH;
         end
`ifdef IFETCH_MISALIGN_CHECK_EN
         S_TRAP: begin
            if (imem_rvalid) owe_d = 1'b0;
         end
`endif
         default: ;
      endcase

      // Redirect wins; a response still owed is squashed via S_FLUSH
      if (redirect) begin
         vld_d       = 1'b0;
         inst_d      = NOP_INST;
         pc_d        = pc_q;
         pc4_d       = pc4_q;
         skid_inst_d = 32'h0;
         skid_pc_d   = 32'h0;
         fpc_d       = tgt;
         state_d     = (pend && !imem_rvalid) ? S_FLUSH : S_FETCH;
`ifdef IFETCH_MISALIGN_CHECK_EN
         mis_d = 1'b0;
         owe_d = 1'b0;
         if (redirect_pc[1:0] != 2'b00) begin
            fpc_d   = fpc_q;
            mis_d   = 1'b1;
            owe_d   = pend && !imem_rvalid;
            state_d = S_TRAP;
         end
`endif
      end

      req_d = (state_d == S_FETCH);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_BOOT;
         fpc_q       <= RESET_PC;
         req_q       <= 1'b0;
         inst_q      <= NOP_INST;
         pc_q        <= RESET_PC;
         pc4_q       <= RESET_PC + 32'd4;
         vld_q       <= 1'b0;
         skid_inst_q <= 32'h0;
         skid_pc_q   <= 32'h0;
      end else begin
         state_q     <= state_d;
         fpc_q       <= fpc_d;
         req_q       <= req_d;
         inst_q      <= inst_d;
         pc_q        <= pc_d;
         pc4_q       <= pc4_d;
         vld_q       <= vld_d;
         skid_inst_q <= skid_inst_d;
         skid_pc_q   <= skid_pc_d;
      end
   end

`ifdef IFETCH_MISALIGN_CHECK_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mis_q <= 1'b0;
         owe_q <= 1'b0;
      end else begin
         mis_q <= mis_d;
         owe_q <= owe_d;
      end
   end

   assign misalign_o = mis_q;
`endif

   assign imem_req   = req_q;
   assign imem_addr  = fpc_q;
   assign inst_o     = inst_q;
   assign pc_o       = pc_q;
   assign pc4_o      = pc4_q;
   assign inst_valid = vld_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: vector table, corner sequences and random traffic against a
// queue-based fetch model, with a variable-latency instruction memory.
module tb_ifetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_rvalid;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] inst_o;
   logic [31:0] pc_o;
   logic [31:0] pc4_o;
   logic        inst_valid;
`ifdef IFETCH_MISALIGN_CHECK_EN
   logic        misalign_o;
`endif

   ifetch_unit dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
      .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .inst_o(inst_o), .pc_o(pc_o), .pc4_o(pc4_o),
      .inst_valid(inst_valid)
`ifdef IFETCH_MISALIGN_CHECK_EN
      , .misalign_o(misalign_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // memory environment: one request at a time, answered in its lat-th cycle
   int          lat = 1;
   logic        pend = 1'b0;
   logic        force_rv = 1'b0;
   int          pcnt, plat;
   logic [31:0] paddr;

   // reference model
   logic        m_boot, m_req, m_valid, m_stale;
   logic [31:0] m_fpc, m_inst, m_pc;
   logic [31:0] skid[$];

   typedef struct {
      logic        st;
      logic        rq;
      logic [31:0] ad;
      logic        vl;
      logic [31:0] pc;
   } vec_t;
   vec_t tbl[9];

   function automatic logic [31:0] memword(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", nm, got, exp);
      end
   endtask

   task automatic mem_step();
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
      if (force_rv) begin
         imem_rvalid = 1'b1;
         imem_rdata  = 32'hBAD0_BAD0;
      end else begin
         if (!pend && imem_req) begin
            pend  = 1'b1;
            paddr = imem_addr;
            plat  = lat;
            pcnt  = 0;
         end
         if (pend) begin
            pcnt++;
            if (pcnt >= plat) begin
               imem_rvalid = 1'b1;
               imem_rdata  = memword(paddr);
               pend        = 1'b0;
            end
         end
      end
   endtask

   task automatic model_reset();
      m_boot  = 1'b1;
      m_req   = 1'b0;
      m_valid = 1'b0;
      m_stale = 1'b0;
      m_fpc   = 32'h0;
      m_inst  = NOP;
      m_pc    = 32'h0;
      skid.delete();
   endtask

   task automatic model_step(input logic st, input logic rd,
                             input logic [31:0] rp, input logic rv);
      logic owed, cons;
      cons = m_valid && !st;
      if (rd) begin
         owed    = (m_req || m_stale) && !rv;
         m_valid = 1'b0;
         m_inst  = NOP;
         skid.delete();
         m_fpc   = rp & 32'hFFFF_FFFC;
         m_stale = owed;
         m_req   = !owed;
         m_boot  = 1'b0;
      end else if (m_boot) begin
         m_boot = 1'b0;
         m_req  = 1'b1;
      end else if (m_stale) begin
         if (rv) begin
            m_stale = 1'b0;
            m_req   = 1'b1;
         end
      end else if (skid.size() != 0) begin
         if (!st) begin
            m_pc    = skid[0];
            m_inst  = memword(m_pc);
            m_valid = 1'b1;
            skid.delete();
            m_req   = 1'b1;
         end
      end else if (rv) begin
         if (!m_valid || !st) begin
            m_valid = 1'b1;
            m_pc    = m_fpc;
            m_inst  = memword(m_fpc);
         end else begin
            skid.push_back(m_fpc);
            m_req = 1'b0;
         end
         m_fpc = m_fpc + 32'd4;
      end else if (cons) begin
         m_valid = 1'b0;
         m_inst  = NOP;
      end
   endtask

   task automatic model_cmp();
      checks++;
      if ({imem_req, imem_addr, inst_valid, inst_o, pc_o, pc4_o} !==
          {m_req, m_fpc, m_valid, m_inst, m_pc, m_pc + 32'd4}) begin
         errors++;
         $display("FAIL model t=%0t req %b/%b addr %h/%h vld %b/%b inst %h/%h pc %h/%h pc4 %h/%h",
                  $time, imem_req, m_req, imem_addr, m_fpc, inst_valid, m_valid,
                  inst_o, m_inst, pc_o, m_pc, pc4_o, m_pc + 32'd4);
      end
   endtask

   task automatic pre(input logic st, input logic rd, input logic [31:0] rp);
      stall       = st;
      redirect    = rd;
      redirect_pc = rp;
      mem_step();
      @(negedge clk);
   endtask

   task automatic post();
      model_step(stall, redirect, redirect_pc, imem_rvalid);
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input logic st, input logic rd, input logic [31:0] rp,
                      input logic use_model);
      pre(st, rd, rp);
      if (use_model) model_cmp();
      post();
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req"},  {31'h0, imem_req},   32'h0);
      chk({tag, "_addr"}, imem_addr,           32'h0);
      chk({tag, "_vld"},  {31'h0, inst_valid}, 32'h0);
      chk({tag, "_inst"}, inst_o,              NOP);
      chk({tag, "_pc"},   pc_o,                32'h0);
      chk({tag, "_pc4"},  pc4_o,               32'h4);
`ifdef IFETCH_MISALIGN_CHECK_EN
      chk({tag, "_mis"},  {31'h0, misalign_o}, 32'h0);
`endif
   endtask

   task automatic do_reset();
      rst         = 1'b0;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      force_rv    = 1'b0;
      pend        = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("rst");
      rst = 1'b1;
      model_reset();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic        s, r;
      logic [31:0] p;

      tbl[0] = '{st:1'b0, rq:1'b0, ad:32'h00, vl:1'b0, pc:32'h0};
      tbl[1] = '{st:1'b0, rq:1'b1, ad:32'h00, vl:1'b0, pc:32'h0};
      tbl[2] = '{st:1'b0, rq:1'b1, ad:32'h04, vl:1'b1, pc:32'h0};
      tbl[3] = '{st:1'b1, rq:1'b1, ad:32'h08, vl:1'b1, pc:32'h4};
      tbl[4] = '{st:1'b1, rq:1'b0, ad:32'h0C, vl:1'b1, pc:32'h4};
      tbl[5] = '{st:1'b1, rq:1'b0, ad:32'h0C, vl:1'b1, pc:32'h4};
      tbl[6] = '{st:1'b0, rq:1'b0, ad:32'h0C, vl:1'b1, pc:32'h4};
      tbl[7] = '{st:1'b0, rq:1'b1, ad:32'h0C, vl:1'b1, pc:32'h8};
      tbl[8] = '{st:1'b0, rq:1'b1, ad:32'h10, vl:1'b1, pc:32'hC};

      rst = 1'b1;
      #3;
      do_reset();

      // boot, 1-cycle memory, 3-cycle stall with skid
      lat = 1;
      for (int i = 0; i < 9; i++) begin
         pre(tbl[i].st, 1'b0, 32'h0);
         checks++;
         if ({imem_req, imem_addr, inst_valid, pc_o, pc4_o, inst_o} !==
             {tbl[i].rq, tbl[i].ad, tbl[i].vl, tbl[i].pc, tbl[i].pc + 32'd4,
              tbl[i].vl ? memword(tbl[i].pc) : NOP}) begin
            errors++;
            $display("FAIL vec%0d req %b/%b addr %h/%h vld %b/%b pc %h/%h inst %h",
                     i, imem_req, tbl[i].rq, imem_addr, tbl[i].ad,
                     inst_valid, tbl[i].vl, pc_o, tbl[i].pc, inst_o);
         end
         model_cmp();
         post();
      end

      // 3-cycle memory, redirect while req@0x10 outstanding
      do_reset();
      lat = 3;
      cyc(1'b0, 1'b1, 32'h10, 1'b1);
      chk("h1_addr10", imem_addr, 32'h10);
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      cyc(1'b0, 1'b1, 32'h100, 1'b1);
      chk("h1_flush_req", {31'h0, imem_req}, 32'h0);
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      chk("h1_addr100", imem_addr, 32'h100);
      chk("h1_req", {31'h0, imem_req}, 32'h1);
      chk("h1_vld0", {31'h0, inst_valid}, 32'h0);
      repeat (3) cyc(1'b0, 1'b0, 32'h0, 1'b1);
      chk("h1_pc", pc_o, 32'h100);
      chk("h1_pc4", pc4_o, 32'h104);
      chk("h1_inst", inst_o, memword(32'h100));

      // redirect in the same cycle as rvalid
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      cyc(1'b0, 1'b1, 32'h200, 1'b1);
      chk("h2_vld0", {31'h0, inst_valid}, 32'h0);
      chk("h2_addr", imem_addr, 32'h200);

      // wrap at top of address space
      lat = 1;
      cyc(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
      chk("h3_addr", imem_addr, 32'hFFFF_FFFC);
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      chk("h3_pc", pc_o, 32'hFFFF_FFFC);
      chk("h3_pc4", pc4_o, 32'h0);
      chk("h3_next", imem_addr, 32'h0);

      // async reset mid-fetch, stray response in boot
      lat = 3;
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      rst = 1'b0;
      #1;
      chk_reset_vals("midrst");
      pend = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
      lat = 1;
      force_rv = 1'b1;
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      force_rv = 1'b0;
      chk("h4_vld0", {31'h0, inst_valid}, 32'h0);
      chk("h4_req", {31'h0, imem_req}, 32'h1);
      chk("h4_addr", imem_addr, 32'h0);
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      chk("h4_pc", pc_o, 32'h0);
      chk("h4_inst", inst_o, memword(32'h0));

`ifdef IFETCH_MISALIGN_CHECK_EN
      do_reset();
      lat = 1;
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      cyc(1'b0, 1'b1, 32'h102, 1'b0);
      chk("mis_set", {31'h0, misalign_o}, 32'h1);
      chk("mis_req0", {31'h0, imem_req}, 32'h0);
      chk("mis_vld0", {31'h0, inst_valid}, 32'h0);
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      chk("mis_sticky", {31'h0, misalign_o}, 32'h1);
      cyc(1'b0, 1'b1, 32'h104, 1'b0);
      chk("mis_clr", {31'h0, misalign_o}, 32'h0);
      chk("mis_addr", imem_addr, 32'h104);
      chk("mis_req1", {31'h0, imem_req}, 32'h1);
`endif

      // random traffic against the model
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         lat = $urandom_range(1, 3);
         s   = ($urandom_range(0, 9) < 3);
         r   = ($urandom_range(0, 19) == 0);
         p   = $urandom();
         if ($urandom_range(0, 3) == 0) p = 32'hFFFF_FFF0 | (p & 32'hF);
`ifdef IFETCH_MISALIGN_CHECK_EN
         p = p & 32'hFFFF_FFFC;
`endif
         cyc(s, r, p, 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
